// File: rtl/usb_rx_unstuffer_pkg.sv
// Shared types and constants for the USB receive-path bit unstuffer.
package usb_rx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      SKIP  = 2'd2,
      ERR   = 2'd3
   } rx_state_t;

   localparam int USB_MAX_ONES = 6;
   localparam int USB_BYTE_W   = 8;

endpackage

// File: rtl/usb_rx_unstuffer.sv
// Removes stuffed zeros from the NRZI-decoded bit stream and assembles LSB-first words,
// flagging stuff violations and packets that end mid-word.
module usb_rx_unstuffer
   import usb_rx_pkg::*;
#(
   parameter int DATA_W   = USB_BYTE_W,
   parameter int MAX_ONES = USB_MAX_ONES
) (
   input  logic              clk,
   input  logic              nRST,
   input  logic              en,
   input  logic              pulse,
   input  logic              decoded_bit,
   output logic [DATA_W-1:0] byte_out,
   output logic              byte_valid,
   output logic              stuff_err,
   output logic              align_err
);

   localparam int ONES_W = $clog2(MAX_ONES + 1);
   localparam int BIT_W  = $clog2(DATA_W + 1);

   rx_state_t          state_r,      state_s;
   logic [ONES_W-1:0]  ones_cnt_r,   ones_cnt_s;
   logic [BIT_W-1:0]   bit_cnt_r,    bit_cnt_s;
   logic [DATA_W-1:0]  shift_r,      shift_s;
   logic [DATA_W-1:0]  byte_out_r,   byte_out_s;
   logic               byte_valid_r, byte_valid_s;
   logic               stuff_err_r,  stuff_err_s;
   logic               align_err_r,  align_err_s;
   logic [DATA_W-1:0]  shifted_s;

   assign byte_out   = byte_out_r;
   assign byte_valid = byte_valid_r;
   assign stuff_err  = stuff_err_r;
   assign align_err  = align_err_r;

   // Next-state, counter and output computation for one clk.
   always_comb begin
      state_s      = state_r;
      ones_cnt_s   = ones_cnt_r;
      bit_cnt_s    = bit_cnt_r;
      shift_s      = shift_r;
      byte_out_s   = byte_out_r;
      byte_valid_s = 1'b0;
      stuff_err_s  = 1'b0;
      align_err_s  = 1'b0;
      shifted_s    = {decoded_bit, shift_r[DATA_W-1:1]};

      if (!en) begin
         // Dropping en clears the packet context; a strobe in this cycle is ignored.
         if (state_r != IDLE) begin
            state_s     = IDLE;
            ones_cnt_s  = {ONES_W{1'b0}};
            bit_cnt_s   = {BIT_W{1'b0}};
            shift_s     = {DATA_W{1'b0}};
            align_err_s = (bit_cnt_r != {BIT_W{1'b0}}) && (state_r != ERR);
         end else begin
            state_s = IDLE;
         end
      end else begin
         case (state_r)
            IDLE, SHIFT: begin
               state_s = SHIFT;
               if (pulse) begin
                  shift_s = shifted_s;
                  if (decoded_bit) begin
                     ones_cnt_s = ones_cnt_r + ONES_W'(1);
                     if (ones_cnt_r == ONES_W'(MAX_ONES - 1)) begin
                        state_s = SKIP;
                     end else begin
                        state_s = SHIFT;
                     end
                  end else begin
                     ones_cnt_s = {ONES_W{1'b0}};
                  end
                  // Word completes on the last data bit, independent of any pending stuff bit.
                  if (bit_cnt_r == BIT_W'(DATA_W - 1)) begin
                     byte_out_s   = shifted_s;
                     byte_valid_s = 1'b1;
                     bit_cnt_s    = {BIT_W{1'b0}};
                  end else begin
                     bit_cnt_s = bit_cnt_r + BIT_W'(1);
                  end
               end else begin
                  shift_s = shift_r;
               end
            end
            SKIP: begin
               if (pulse) begin
                  if (decoded_bit) begin
                     stuff_err_s = 1'b1;
                     state_s     = ERR;
                  end else begin
                     ones_cnt_s = {ONES_W{1'b0}};
                     state_s    = SHIFT;
                  end
               end else begin
                  state_s = SKIP;
               end
            end
            ERR: begin
               state_s = ERR;
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end
   end

   // State, counters, shift register and registered outputs.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_r      <= IDLE;
         ones_cnt_r   <= {ONES_W{1'b0}};
         bit_cnt_r    <= {BIT_W{1'b0}};
         shift_r      <= {DATA_W{1'b0}};
         byte_out_r   <= {DATA_W{1'b0}};
         byte_valid_r <= 1'b0;
         stuff_err_r  <= 1'b0;
         align_err_r  <= 1'b0;
      end else begin
         state_r      <= state_s;
         ones_cnt_r   <= ones_cnt_s;
         bit_cnt_r    <= bit_cnt_s;
         shift_r      <= shift_s;
         byte_out_r   <= byte_out_s;
         byte_valid_r <= byte_valid_s;
         stuff_err_r  <= stuff_err_s;
         align_err_r  <= align_err_s;
      end
   end

endmodule

// File: tb/tb_usb_rx_unstuffer.sv
// Directed self-checking bench for usb_rx_unstuffer.
module tb_usb_rx_unstuffer;

   logic       clk;
   logic       nRST;
   logic       en;
   logic       pulse;
   logic       decoded_bit;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       stuff_err;
   logic       align_err;

   int tests;
   int fails;
   int vld_cnt;
   int stf_cnt;
   int aln_cnt;
   int vld_base;
   int stf_base;
   int aln_base;

   usb_rx_unstuffer dut (
      .clk         (clk),
      .nRST        (nRST),
      .en          (en),
      .pulse       (pulse),
      .decoded_bit (decoded_bit),
      .byte_out    (byte_out),
      .byte_valid  (byte_valid),
      .stuff_err   (stuff_err),
      .align_err   (align_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters sampled mid-cycle so that multi-cycle or missing pulses are visible.
   always @(negedge clk) begin
      if (byte_valid === 1'b1) vld_cnt <= vld_cnt + 1;
      if (stuff_err === 1'b1)  stf_cnt <= stf_cnt + 1;
      if (align_err === 1'b1)  aln_cnt <= aln_cnt + 1;
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic b);
      decoded_bit = b;
      pulse       = 1'b1;
      @(posedge clk);
      #1;
      pulse       = 1'b0;
   endtask

   // Sends n bits LSB first with an idle cycle between strobes; returns just after the last one.
   task automatic send(input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         if (i > 0) idle();
         strobe(bits[i]);
      end
   endtask

   task automatic snap();
      vld_base = vld_cnt;
      stf_base = stf_cnt;
      aln_base = aln_cnt;
   endtask

   initial begin
      tests = 0; fails = 0;
      vld_cnt = 0; stf_cnt = 0; aln_cnt = 0;
      nRST = 1'b0; en = 1'b0; pulse = 1'b0; decoded_bit = 1'b0;
      idle(); idle();
      chk8("rst_byte_out", byte_out, 8'h00);
      chk1("rst_valid", byte_valid, 1'b0);
      chk1("rst_stuff", stuff_err, 1'b0);
      chk1("rst_align", align_err, 1'b0);
      nRST = 1'b1;
      idle();

      // Plain byte A5
      snap();
      en = 1'b1;
      send(16'h00A5, 8);
      chk1("a5_valid", byte_valid, 1'b1);
      chk8("a5_byte", byte_out, 8'hA5);
      chk1("a5_stuff", stuff_err, 1'b0);
      idle();
      chk1("a5_valid_drop", byte_valid, 1'b0);
      chk8("a5_hold", byte_out, 8'hA5);
      en = 1'b0;
      idle(); idle();
      chkn("a5_valid_count", vld_cnt - vld_base, 1);
      chkn("a5_no_align", aln_cnt - aln_base, 0);

      // Six ones, stuffed zero, two ones -> FF
      snap();
      en = 1'b1;
      send(16'h01BF, 9);
      chk1("ff_valid", byte_valid, 1'b1);
      chk8("ff_byte", byte_out, 8'hFF);
      idle();
      chkn("ff_valid_count", vld_cnt - vld_base, 1);
      chkn("ff_no_stuff", stf_cnt - stf_base, 0);
      en = 1'b0;
      idle(); idle();

      // Seven ones -> stuff violation, rest ignored
      snap();
      en = 1'b1;
      send(16'h007F, 7);
      chk1("viol_stuff", stuff_err, 1'b1);
      chk1("viol_valid", byte_valid, 1'b0);
      idle();
      chk1("viol_stuff_drop", stuff_err, 1'b0);
      send(16'h0055, 8);
      idle();
      chkn("viol_stuff_count", stf_cnt - stf_base, 1);
      chkn("viol_no_valid", vld_cnt - vld_base, 0);
      chk8("viol_hold", byte_out, 8'hFF);
      en = 1'b0;
      idle(); idle();
      chkn("viol_no_align", aln_cnt - aln_base, 0);

      // FC ending in six ones, stuffed zero, then 01
      snap();
      en = 1'b1;
      send(16'h00FC, 8);
      chk1("fc_valid", byte_valid, 1'b1);
      chk8("fc_byte", byte_out, 8'hFC);
      idle();
      send(16'h0002, 9);
      chk1("01_valid", byte_valid, 1'b1);
      chk8("01_byte", byte_out, 8'h01);
      idle();
      chkn("fc01_valid_count", vld_cnt - vld_base, 2);
      chkn("fc01_no_stuff", stf_cnt - stf_base, 0);
      en = 1'b0;
      idle(); idle();

      // Partial word then en drop -> align error
      snap();
      en = 1'b1;
      send(16'h0005, 3);
      en = 1'b0;
      idle();
      chk1("align_pulse", align_err, 1'b1);
      chk1("align_no_valid", byte_valid, 1'b0);
      chk8("align_hold", byte_out, 8'h01);
      idle();
      chk1("align_drop", align_err, 1'b0);
      en = 1'b1;
      send(16'h003C, 8);
      chk1("3c_valid", byte_valid, 1'b1);
      chk8("3c_byte", byte_out, 8'h3C);
      en = 1'b0;
      idle(); idle();
      chkn("3c_align_count", aln_cnt - aln_base, 1);
      chkn("3c_valid_count", vld_cnt - vld_base, 1);

      // Reset mid-byte then clean 5A
      en = 1'b1;
      send(16'h000A, 4);
      nRST = 1'b0;
      #1;
      chk8("arst_byte_out", byte_out, 8'h00);
      chk1("arst_valid", byte_valid, 1'b0);
      chk1("arst_stuff", stuff_err, 1'b0);
      chk1("arst_align", align_err, 1'b0);
      idle();
      nRST = 1'b1;
      idle();
      snap();
      send(16'h005A, 8);
      chk1("5a_valid", byte_valid, 1'b1);
      chk8("5a_byte", byte_out, 8'h5A);
      idle();
      chkn("5a_valid_count", vld_cnt - vld_base, 1);
      en = 1'b0;
      idle(); idle();
      chkn("5a_no_align", aln_cnt - aln_base, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/usb_rx_unstuffer.md
Name: usb_rx_unstuffer

Overview:
- Receive-path stage directly downstream of the NRZI decoder.
- Consumes decoded serial bits qualified by the bit strobe.
- Removes the stuffed zero that follows every run of six consecutive ones, and assembles the remaining bits LSB-first into bytes.
- Flags bit-stuff violations and packets that end mid-byte, for the packet-level receiver.

Parameters:
- DATA_W, 8, width of the assembled word.
- MAX_ONES, 6, length of the run of ones after which the next bit must be a stuffed zero.

Ports:
- clk  input  1  system clock
- nRST  input  1  asynchronous active-low reset
- en  input  1  high while a packet is being received; low means idle and clear
- pulse  input  1  bit strobe; decoded_bit is valid in cycles where pulse=1
- decoded_bit  input  1  NRZI-decoded serial bit
- byte_out  output  DATA_W  last assembled word; holds until the next word completes
- byte_valid  output  1  one-cycle pulse, byte_out updated this cycle
- stuff_err  output  1  one-cycle pulse on a bit-stuff violation
- align_err  output  1  one-cycle pulse when en falls with a partial word pending

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (nRST).
- Reset values: byte_out=0, byte_valid=0, stuff_err=0, align_err=0, state=IDLE, ones_cnt=0, bit_cnt=0, shift register=0. All outputs are registered.
- States:
  - IDLE: en=0, or before the first bit.
  - SHIFT: accepting data bits.
  - SKIP: next strobed bit must be a stuffed zero.
  - ERR: violation seen; absorbs the rest of the packet.
- IDLE, en=1: move to SHIFT. If pulse=1 in the same cycle, process the bit exactly as in SHIFT.
- SHIFT, pulse=1, bit=1:
  - Shift the bit in at the MSB end; the word fills LSB-first.
  - ones_cnt++.
  - If ones_cnt reaches MAX_ONES, go to SKIP.
- SHIFT, pulse=1, bit=0: shift it in; ones_cnt=0.
- Word completion:
  - On every shifted data bit, bit_cnt++.
  - When the DATA_W-th bit is shifted, in the following cycle: byte_out=completed word, byte_valid=1, bit_cnt=0.
  - Latency is one clk from the strobe of the last bit to byte_valid.
- SKIP, pulse=1, bit=0:
  - Discard the bit; ones_cnt=0; bit_cnt unchanged.
  - Return to SHIFT.
- SKIP, pulse=1, bit=1:
  - stuff_err=1 for one cycle (the cycle after the strobe).
  - Go to ERR. No further byte_valid until the next packet.
- ERR: ignore all strobes; stay until en=0.
- ones_cnt carries across word boundaries. A sixth one that is bit DATA_W-1 still emits the word; the stuffed zero is removed ahead of the next word's bit 0.
- pulse=0 in any state: no change to counters, shift register or state, except for en handling.
- en=0 in any non-IDLE state:
  - Next cycle: state=IDLE, ones_cnt=0, bit_cnt=0, shift register cleared.
  - byte_out holds its value.
  - If bit_cnt≠0 and state≠ERR: align_err=1 for one cycle.
  - A strobe coinciding with en=0 is ignored.
- Simultaneous completion and violation are impossible, because a stuff bit is never a data bit.
- Asynchronous reset mid-byte abandons the partial word immediately.
- ones_cnt width is clog2(MAX_ONES+1); bit_cnt width is clog2(DATA_W+1).

Decomposition:
- Shared package usb_rx_pkg holds:
  - the state enum type (IDLE, SHIFT, SKIP, ERR);
  - the constant USB_MAX_ONES=6;
  - the constant USB_BYTE_W=8.
- Single module; no sub-module is warranted.
- The counters and shift register sit in one always_ff. Next-state logic sits in one always_comb.

Test Plan:
- Reset, then en=1, strobe bits 1,0,1,0,0,1,0,1 -> byte_valid pulse one cycle after the 8th strobe, byte_out=8'hA5, stuff_err=0.
- Strobe 1×6, 0 (stuffed), 1,1 -> one byte_valid with byte_out=8'hFF after the 9th strobe; the stuffed 0 does not count as a bit.
- Strobe 1×8 (0xFF, no stuff after bit 5) -> stuff_err pulse after the 7th strobe, no byte_valid; further strobes are ignored until en toggles low then high.
- Strobe 0,0,1,1,1,1,1,1 (0xFC, six ones ending at bit 7), then 0 (stuffed), then 8'h01 bits -> bytes 8'hFC then 8'h01, no error.
- Strobe three bits, then drop en -> align_err pulse one cycle later, no byte_valid; byte_out keeps its prior value. Re-raise en and send 8'h3C -> clean byte.
- Assert nRST low after four bits of a byte -> all outputs 0 immediately. Release, en=1, send 8'h5A -> byte_out=8'h5A with no corruption from the partial word.
